// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - hazard/stall controller signal bundle
interface hazard_stall_controller_if #(
    parameter int COUNT_W = 16
);
    logic               id_valid;
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic               id_uses_rs2;
    logic               ex_valid;
    logic               ex_mem_read;
    logic [4:0]         ex_rd;
    logic               branch_taken;
    logic               mem_req;
    logic               mem_ready;
    logic               pc_write;
    logic               ifid_write;
    logic               ifid_flush;
    logic               idex_bubble;
    logic               pipe_hold;
    logic [1:0]         state;
    logic [COUNT_W-1:0] stall_count;
    logic               mem_timeout;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, ex_valid, ex_mem_read, ex_rd,
               branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state,
               stall_count, mem_timeout
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, ex_valid, ex_mem_read, ex_rd,
               branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state,
               stall_count, mem_timeout
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - 5-stage pipeline load-use/branch/memory stall sequencer
module hazard_stall_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int COUNT_W      = 16,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_stall_controller_if.slave hs
);
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    localparam logic [2:0]         FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0]         TIMEOUT_V    = 8'(MEM_TIMEOUT);
    localparam logic [COUNT_W-1:0] STALL_MAX    = {COUNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [2:0]         flush_cnt_q, flush_cnt_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic [COUNT_W-1:0] stall_count_q, stall_count_d;
    logic               mem_timeout_q, mem_timeout_d;

    logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, pipe_hold_c;
    logic run_eval;
    logic load_use;
    logic mem_stall;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign load_use = hs.ex_valid & hs.ex_mem_read & (hs.ex_rd != 5'd0) & hs.id_valid &
                      ((hs.ex_rd == hs.id_rs1) | (hs.id_uses_rs2 & (hs.ex_rd == hs.id_rs2)));
    assign mem_stall = hs.mem_req & ~hs.mem_ready;

    // Next-state and control outputs; memory hold outranks branch, branch outranks load-use
    always_comb begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        pipe_hold_c   = 1'b0;
        run_eval      = 1'b0;
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        case (state_q)
            ST_RUN, ST_LOAD_STALL: begin
                if (mem_stall) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    pipe_hold_c  = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = 8'd1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!hs.mem_ready) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    pipe_hold_c  = 1'b1;
                    wait_cnt_d   = (wait_cnt_q == 8'hff) ? 8'hff : wait_cnt_q + 8'd1;
                end else begin
                    // The completing cycle is evaluated like RUN so no cycle is lost
                    run_eval = 1'b1;
                end
            end
            default: begin
                if (mem_stall) begin
                    // Flush progress is frozen while memory holds the back end
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    pipe_hold_c  = 1'b1;
                end else begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    if (hs.branch_taken) begin
                        flush_cnt_d = FLUSH_RELOAD;
                        state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end else if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            end
        endcase

        if (run_eval) begin
            if (hs.branch_taken) begin
                ifid_flush_c  = 1'b1;
                idex_bubble_c = 1'b1;
                flush_cnt_d   = FLUSH_RELOAD;
                state_d       = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            end else if (load_use) begin
                pc_write_c    = 1'b0;
                ifid_write_c  = 1'b0;
                idex_bubble_c = 1'b1;
                state_d       = ST_LOAD_STALL;
            end else begin
                state_d = ST_RUN;
            end
        end

        if (pipe_hold_c && (state_d == ST_MEM_WAIT) && (wait_cnt_d == TIMEOUT_V)) begin
            mem_timeout_d = 1'b1;
        end

        stall_count_d = (!pc_write_c && (stall_count_q != STALL_MAX)) ?
                        stall_count_q + 1'b1 : stall_count_q;
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 3'd0;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Reset forces a bubbled, frozen front end regardless of state
    assign hs.pc_write    = reset ? pc_write_c    : 1'b0;
    assign hs.ifid_write  = reset ? ifid_write_c  : 1'b0;
    assign hs.ifid_flush  = reset ? ifid_flush_c  : 1'b1;
    assign hs.idex_bubble = reset ? idex_bubble_c : 1'b1;
    assign hs.pipe_hold   = reset ? pipe_hold_c   : 1'b0;
    assign hs.state       = state_q;
    assign hs.stall_count = stall_count_q;
    assign hs.mem_timeout = mem_timeout_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;
    // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state[1:0]}
    localparam logic [6:0] N_RUN  = 7'b1100000;
    localparam logic [6:0] N_LS   = 7'b1100001;
    localparam logic [6:0] LU     = 7'b0001000;
    localparam logic [6:0] LU_LS  = 7'b0001001;
    localparam logic [6:0] BR_RUN = 7'b1111000;
    localparam logic [6:0] FL     = 7'b1111011;
    localparam logic [6:0] H_RUN  = 7'b0000100;
    localparam logic [6:0] H_MW   = 7'b0000110;
    localparam logic [6:0] H_FL   = 7'b0000111;
    localparam logic [6:0] RDY_MW = 7'b1100010;
    localparam logic [6:0] BR_MW  = 7'b1111010;
    localparam logic [6:0] RST    = 7'b0011000;

    typedef struct packed {
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic       exv;
        logic       exm;
        logic [4:0] rd;
        logic       br;
        logic       mq;
        logic       mr;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_controller_if #(.COUNT_W(16)) if_a ();
    hazard_stall_controller_if #(.COUNT_W(2))  if_b ();

    hazard_stall_controller #(.FLUSH_CYCLES(2), .COUNT_W(16), .MEM_TIMEOUT(15)) dut_a (
        .clk(clk), .reset(reset), .hs(if_a));
    hazard_stall_controller #(.FLUSH_CYCLES(1), .COUNT_W(2), .MEM_TIMEOUT(3)) dut_b (
        .clk(clk), .reset(reset), .hs(if_b));

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall_a = 0;
    int exp_stall_b = 0;
    logic [13:0] sb_q[$];

    function automatic stim_t mk(logic idv, logic [4:0] rs1, logic [4:0] rs2, logic u2,
                                 logic exv, logic exm, logic [4:0] rd,
                                 logic br, logic mq, logic mr);
        return '{idv, rs1, rs2, u2, exv, exm, rd, br, mq, mr};
    endfunction

    function automatic stim_t nop();
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t lu5();
        return mk(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t br();
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic stim_t mem(logic rdy);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, rdy);
    endfunction

    function automatic logic [13:0] obs();
        return {if_a.pc_write, if_a.ifid_write, if_a.ifid_flush, if_a.idex_bubble,
                if_a.pipe_hold, if_a.state,
                if_b.pc_write, if_b.ifid_write, if_b.ifid_flush, if_b.idex_bubble,
                if_b.pipe_hold, if_b.state};
    endfunction

    function automatic logic [1:0] sat_b(int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    task automatic apply(stim_t s);
        if_a.id_valid = s.idv;  if_b.id_valid = s.idv;
        if_a.id_rs1 = s.rs1;    if_b.id_rs1 = s.rs1;
        if_a.id_rs2 = s.rs2;    if_b.id_rs2 = s.rs2;
        if_a.id_uses_rs2 = s.u2; if_b.id_uses_rs2 = s.u2;
        if_a.ex_valid = s.exv;  if_b.ex_valid = s.exv;
        if_a.ex_mem_read = s.exm; if_b.ex_mem_read = s.exm;
        if_a.ex_rd = s.rd;      if_b.ex_rd = s.rd;
        if_a.branch_taken = s.br; if_b.branch_taken = s.br;
        if_a.mem_req = s.mq;    if_b.mem_req = s.mq;
        if_a.mem_ready = s.mr;  if_b.mem_ready = s.mr;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        apply(lu5());
        #12;
        got = obs();
        n_cmp++;
        if (got !== {RST, RST}) begin
            n_err++;
            $display("FAIL reset_outputs got=%b exp=%b", got, {RST, RST});
        end
        n_cmp++;
        if (if_a.stall_count !== 16'd0 || if_b.stall_count !== 2'd0) begin
            n_err++;
            $display("FAIL reset_stall_count got=%0d/%0d exp=0", if_a.stall_count, if_b.stall_count);
        end
        n_cmp++;
        if (if_a.mem_timeout !== 1'b0 || if_b.mem_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mem_timeout got=%b/%b exp=0", if_a.mem_timeout, if_b.mem_timeout);
        end
        @(negedge clk);
        apply(nop());
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t       s[6];
        logic [13:0] e[6];
        logic [13:0] ex;
        s = '{lu5(), nop(), nop(), lu5(), lu5(), nop()};
        e = '{{LU, LU}, {N_LS, N_LS}, {N_RUN, N_RUN}, {LU, LU}, {LU_LS, LU_LS}, {N_LS, N_LS}};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apply(s[i]);
            sb_q.push_back(e[i]);
            if (!e[i][13]) exp_stall_a++;
            if (!e[i][6]) exp_stall_b++;
            #2;
            ex = sb_q.pop_front();
            n_cmp++;
            if (obs() !== ex) begin
                n_err++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, obs(), ex);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (if_a.stall_count !== 16'(exp_stall_a) || if_b.stall_count !== sat_b(exp_stall_b)) begin
            n_err++;
            $display("FAIL load_use_stall_count got=%0d/%0d exp=%0d/%0d", if_a.stall_count,
                     if_b.stall_count, exp_stall_a, sat_b(exp_stall_b));
        end
    endtask

    task automatic test_no_hazard();
        stim_t       s[6];
        logic [13:0] e[6];
        logic [13:0] ex;
        s = '{mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0), mk(1, 1, 5, 0, 1, 1, 5, 0, 0, 0),
              mk(1, 5, 0, 0, 0, 1, 5, 0, 0, 0), mk(1, 1, 5, 1, 1, 1, 5, 0, 0, 0), nop(), nop()};
        e = '{{N_RUN, N_RUN}, {N_RUN, N_RUN}, {N_RUN, N_RUN}, {LU, LU}, {N_LS, N_LS}, {N_RUN, N_RUN}};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apply(s[i]);
            sb_q.push_back(e[i]);
            if (!e[i][13]) exp_stall_a++;
            if (!e[i][6]) exp_stall_b++;
            #2;
            ex = sb_q.pop_front();
            n_cmp++;
            if (obs() !== ex) begin
                n_err++;
                $display("FAIL no_hazard[%0d] got=%b exp=%b", i, obs(), ex);
            end
        end
    endtask

    task automatic test_flush();
        stim_t       s[10];
        logic [13:0] e[10];
        logic [13:0] ex;
        s = '{br(), nop(), nop(), br(), lu5(), nop(), br(), br(), nop(), nop()};
        e = '{{BR_RUN, BR_RUN}, {FL, N_RUN}, {N_RUN, N_RUN}, {BR_RUN, BR_RUN}, {FL, LU},
              {N_RUN, N_LS}, {BR_RUN, BR_RUN}, {FL, BR_RUN}, {FL, N_RUN}, {N_RUN, N_RUN}};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(s[i]);
            sb_q.push_back(e[i]);
            if (!e[i][13]) exp_stall_a++;
            if (!e[i][6]) exp_stall_b++;
            #2;
            ex = sb_q.pop_front();
            n_cmp++;
            if (obs() !== ex) begin
                n_err++;
                $display("FAIL flush[%0d] got=%b exp=%b", i, obs(), ex);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (if_a.stall_count !== 16'(exp_stall_a) || if_b.stall_count !== sat_b(exp_stall_b)) begin
            n_err++;
            $display("FAIL flush_stall_count got=%0d/%0d exp=%0d/%0d", if_a.stall_count,
                     if_b.stall_count, exp_stall_a, sat_b(exp_stall_b));
        end
    endtask

    task automatic test_mem_wait();
        stim_t       s[10];
        logic [13:0] e[10];
        logic [13:0] ex;
        s = '{mem(0), mem(0), mem(0), mem(0), mem(1), nop(), br(), mem(0), mem(1), nop()};
        e = '{{H_RUN, H_RUN}, {H_MW, H_MW}, {H_MW, H_MW}, {H_MW, H_MW}, {RDY_MW, RDY_MW},
              {N_RUN, N_RUN}, {BR_RUN, BR_RUN}, {H_FL, H_RUN}, {FL, RDY_MW}, {N_RUN, N_RUN}};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(s[i]);
            sb_q.push_back(e[i]);
            if (!e[i][13]) exp_stall_a++;
            if (!e[i][6]) exp_stall_b++;
            #2;
            ex = sb_q.pop_front();
            n_cmp++;
            if (obs() !== ex) begin
                n_err++;
                $display("FAIL mem_wait[%0d] got=%b exp=%b", i, obs(), ex);
            end
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (if_b.mem_timeout !== (i == 3)) begin
                    n_err++;
                    $display("FAIL mem_timeout_edge[%0d] got=%b exp=%b", i, if_b.mem_timeout, i == 3);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (if_a.stall_count !== 16'(exp_stall_a) || if_b.stall_count !== sat_b(exp_stall_b)) begin
            n_err++;
            $display("FAIL mem_stall_count got=%0d/%0d exp=%0d/%0d", if_a.stall_count,
                     if_b.stall_count, exp_stall_a, sat_b(exp_stall_b));
        end
        n_cmp++;
        if (if_a.mem_timeout !== 1'b0 || if_b.mem_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL mem_timeout_sticky got=%b/%b exp=0/1", if_a.mem_timeout, if_b.mem_timeout);
        end
    endtask

    task automatic test_simultaneous();
        stim_t       s[4];
        logic [13:0] e[4];
        logic [13:0] ex;
        s = '{mk(1, 5, 0, 0, 1, 1, 5, 1, 1, 0), mk(1, 5, 0, 0, 1, 1, 5, 1, 1, 1), nop(), nop()};
        e = '{{H_RUN, H_RUN}, {BR_MW, BR_MW}, {FL, N_RUN}, {N_RUN, N_RUN}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply(s[i]);
            sb_q.push_back(e[i]);
            if (!e[i][13]) exp_stall_a++;
            if (!e[i][6]) exp_stall_b++;
            #2;
            ex = sb_q.pop_front();
            n_cmp++;
            if (obs() !== ex) begin
                n_err++;
                $display("FAIL simultaneous[%0d] got=%b exp=%b", i, obs(), ex);
            end
        end
    endtask

    task automatic test_reset_async();
        // mid-MEM_WAIT
        @(negedge clk); apply(mem(0));
        @(negedge clk); #2;
        n_cmp++;
        if (if_a.state !== 2'd2) begin
            n_err++;
            $display("FAIL pre_reset_mem_wait state got=%0d exp=2", if_a.state);
        end
        #1 reset = 1'b0;
        exp_stall_a = 0;
        exp_stall_b = 0;
        #1;
        n_cmp++;
        if (obs() !== {RST, RST} || if_a.stall_count !== 16'd0 || if_b.mem_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_mem_wait got=%b cnt=%0d tmo=%b exp=%b cnt=0 tmo=0", obs(),
                     if_a.stall_count, if_b.mem_timeout, {RST, RST});
        end
        @(negedge clk); apply(nop()); reset = 1'b1; #2;
        n_cmp++;
        if (obs() !== {N_RUN, N_RUN}) begin
            n_err++;
            $display("FAIL release_after_mem_wait got=%b exp=%b", obs(), {N_RUN, N_RUN});
        end
        // mid-FLUSH
        @(negedge clk); apply(br());
        @(negedge clk); apply(nop()); #2;
        n_cmp++;
        if (if_a.state !== 2'd3) begin
            n_err++;
            $display("FAIL pre_reset_flush state got=%0d exp=3", if_a.state);
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== {RST, RST} || if_a.stall_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid_flush got=%b cnt=%0d exp=%b cnt=0", obs(), if_a.stall_count,
                     {RST, RST});
        end
        @(negedge clk); reset = 1'b1; #2;
        n_cmp++;
        if (obs() !== {N_RUN, N_RUN} || if_a.stall_count !== 16'(exp_stall_a)) begin
            n_err++;
            $display("FAIL release_after_flush got=%b cnt=%0d exp=%b cnt=0", obs(),
                     if_a.stall_count, {N_RUN, N_RUN});
        end
    endtask

    initial begin
        apply(nop());
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_mem_wait();
        test_simultaneous();
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
